// File: rtl/sprite_mover.sv
// sprite_mover: holds one square sprite's centre position and moves it on a
// divided move tick from four active-low buttons. It clamps the sprite to the
// visible area and supports optional gravity, respawn, step/auto-repeat mode
// and a landed flag. It also answers a registered "pixel inside sprite" query
// for the pixel generator.
//
// Ports:
//   clk        system/pixel clock
//   resetn     asynchronous active-low reset
//   btn_n      active-low buttons: [0] left, [1] right, [2] up, [3] down
//   mode       0 = continuous move while held, 1 = step with auto-repeat
//   grav_en    1 = sprite falls by STEP every GRAV_DIV move ticks
//   respawn    synchronous pulse, reloads the initial position
//   pix_x/y    pixel being drawn
//   in_sprite  hit result for the previous cycle's pixel
//   sprite_x/y current sprite centre
//   landed     1 while sprite_y sits on the bottom limit
//   tick       one-cycle pulse per move tick
//
// Step-mode FSM:
//   state  | meaning
//   IDLE   | no button held, next press moves at once
//   DELAY  | press accepted, counting ticks before auto-repeat
//   REPEAT | auto-repeat, move on every tick while press is unchanged
module sprite_mover #(
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int HALF       = 25,
  parameter int X_INIT     = 320,
  parameter int Y_INIT     = 240,
  parameter int STEP       = 1,
  parameter int TICK_DIV   = 100000,
  parameter int REPEAT_DLY = 8,
  parameter int GRAV_DIV   = 16
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [3:0]     btn_n,
  input  logic           mode,
  input  logic           grav_en,
  input  logic           respawn,
  input  logic [X_W-1:0] pix_x,
  input  logic [Y_W-1:0] pix_y,
  output logic           in_sprite,
  output logic [X_W-1:0] sprite_x,
  output logic [Y_W-1:0] sprite_y,
  output logic           landed,
  output logic           tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RPT_W = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;
  localparam int GRV_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_DLY - 1);
  localparam logic [GRV_W-1:0] GRV_LAST = GRV_W'(GRAV_DIV - 1);

  // Signed working copies, one bit wider than the coordinates
  localparam logic signed [X_W:0] X_MIN_S  = (X_W+1)'(HALF);
  localparam logic signed [X_W:0] X_MAX_S  = (X_W+1)'(H_RES - HALF);
  localparam logic signed [X_W:0] X_STEP_S = (X_W+1)'(STEP);
  localparam logic signed [X_W:0] X_HALF_S = (X_W+1)'(HALF);
  localparam logic signed [Y_W:0] Y_MIN_S  = (Y_W+1)'(HALF);
  localparam logic signed [Y_W:0] Y_MAX_S  = (Y_W+1)'(V_RES - HALF);
  localparam logic signed [Y_W:0] Y_STEP_S = (Y_W+1)'(STEP);
  localparam logic signed [Y_W:0] Y_HALF_S = (Y_W+1)'(HALF);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t           state, state_nxt;
  logic [RPT_W-1:0] rpt, rpt_nxt;
  logic [3:0]       last_press, last_nxt;
  logic [CNT_W-1:0] cnt;
  logic [GRV_W-1:0] gcnt;
  logic [3:0]       press;
  logic             move_ok;
  logic             grav_force;
  logic             go_left, go_right, go_up, go_down;
  logic signed [X_W:0] sx_w, x_cand, px_w;
  logic signed [Y_W:0] sy_w, y_cand, py_w;
  logic [X_W-1:0]   x_next;
  logic [Y_W-1:0]   y_next;

  assign press = ~btn_n;

  // Tick divider
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      tick <= (cnt == CNT_LAST);
    end
  end

  // Step-mode FSM: the next-state logic assumes a tick, and the registers
  // only load on tick cycles. Continuous mode parks the FSM in IDLE.
  always_comb begin
    state_nxt = state;
    rpt_nxt   = rpt;
    last_nxt  = last_press;
    move_ok   = 1'b0;
    if (!mode) begin
      move_ok   = 1'b1;
      state_nxt = IDLE;
      rpt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (press != 4'b0) begin
            move_ok   = 1'b1;
            state_nxt = DELAY;
            rpt_nxt   = '0;
            last_nxt  = press;
          end
        end
        DELAY: begin
          if (press == 4'b0) begin
            state_nxt = IDLE;
          end else if (press != last_press) begin
            move_ok  = 1'b1;
            rpt_nxt  = '0;
            last_nxt = press;
          end else if (rpt == RPT_LAST) begin
            move_ok   = 1'b1;
            state_nxt = REPEAT;
          end else begin
            rpt_nxt = rpt + 1'b1;
          end
        end
        REPEAT: begin
          if (press == 4'b0) begin
            state_nxt = IDLE;
          end else if (press != last_press) begin
            move_ok   = 1'b1;
            state_nxt = DELAY;
            rpt_nxt   = '0;
            last_nxt  = press;
          end else begin
            move_ok = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      rpt        <= '0;
      last_press <= 4'b0;
    end else if (respawn) begin
      state      <= IDLE;
      rpt        <= '0;
      last_press <= 4'b0;
    end else if (tick) begin
      state      <= state_nxt;
      rpt        <= rpt_nxt;
      last_press <= last_nxt;
    end
  end

  // Gravity counter
  assign grav_force = grav_en && (gcnt == GRV_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gcnt <= '0;
    end else if (respawn || !grav_en) begin
      gcnt <= '0;
    end else if (tick) begin
      gcnt <= (gcnt == GRV_LAST) ? '0 : gcnt + 1'b1;
    end
  end

  // Opposing buttons cancel. Gravity merges with a held down button into a
  // single step and cancels against a held up button.
  assign go_left  = move_ok && press[0] && !press[1];
  assign go_right = move_ok && press[1] && !press[0];
  assign go_up    = move_ok && press[2] && !press[3];
  assign go_down  = (move_ok && press[3] && !press[2]) || grav_force;

  assign sx_w = $signed({1'b0, sprite_x});
  assign sy_w = $signed({1'b0, sprite_y});

  always_comb begin
    x_cand = sx_w;
    if (go_left)  x_cand = sx_w - X_STEP_S;
    if (go_right) x_cand = sx_w + X_STEP_S;
    if (x_cand < X_MIN_S)      x_next = X_W'(HALF);
    else if (x_cand > X_MAX_S) x_next = X_W'(H_RES - HALF);
    else                       x_next = x_cand[X_W-1:0];
  end

  always_comb begin
    y_cand = sy_w;
    if (go_up && !go_down) y_cand = sy_w - Y_STEP_S;
    if (go_down && !go_up) y_cand = sy_w + Y_STEP_S;
    if (y_cand < Y_MIN_S)      y_next = Y_W'(HALF);
    else if (y_cand > Y_MAX_S) y_next = Y_W'(V_RES - HALF);
    else                       y_next = y_cand[Y_W-1:0];
  end

  // Position, landed flag and hit query
  assign px_w = $signed({1'b0, pix_x});
  assign py_w = $signed({1'b0, pix_y});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sprite_x  <= X_W'(X_INIT);
      sprite_y  <= Y_W'(Y_INIT);
      landed    <= 1'b0;
      in_sprite <= 1'b0;
    end else begin
      if (respawn) begin
        sprite_x <= X_W'(X_INIT);
        sprite_y <= Y_W'(Y_INIT);
      end else if (tick) begin
        sprite_x <= x_next;
        sprite_y <= y_next;
      end
      // Respawn always lifts the sprite off the floor, so drop the flag now
      landed    <= respawn ? 1'b0 : (sprite_y == Y_W'(V_RES - HALF));
      in_sprite <= (px_w > sx_w - X_HALF_S) && (px_w < sx_w + X_HALF_S) &&
                   (py_w > sy_w - Y_HALF_S) && (py_w < sy_w + Y_HALF_S);
    end
  end

endmodule
